wb_arbiter: RTL and testbench

Writeback stage directly upstream of the 32x32 register file. It merges two result sources onto the regfile's single write port:
- single-cycle ALU results, which are never stalled;
- long-latency LSU/mul-div results, buffered in a small FIFO behind a valid/ready handshake.

It drives registered write-port signals (wr_en/wr_idx/wr_data) and gives decode a same-cycle bypass plus a pending-destination mask for hazard detection.

---
 rtl/wb_arbiter_if.sv | 59 +++++
 rtl/wb_arbiter.sv | 136 +++++++++++++
 tb/tb_wb_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter_if
//  Description : Bundle of the writeback arbiter's result-source, regfile
//                write-port, bypass and hazard-mask signals.
//  Revision    : 1.0  initial release
// ============================================================================
interface wb_arbiter_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
);
    localparam int c_CW = $clog2(DEPTH) + 1;

    // ALU result source (never stalled)
    logic            alu_valid;
    logic [4:0]      alu_idx;
    logic [XLEN-1:0] alu_data;
    // LSU / mul-div result source (valid/ready)
    logic            lsu_valid;
    logic [4:0]      lsu_idx;
    logic [XLEN-1:0] lsu_data;
    logic            lsu_ready;
    // Regfile write port
    logic            rf_wr_en;
    logic [4:0]      rf_wr_idx;
    logic [XLEN-1:0] rf_wr_data;
    // Decode bypass and hazard information
    logic [4:0]      rda_idx;
    logic [4:0]      rdb_idx;
    logic            byp_a_hit;
    logic [XLEN-1:0] byp_a_data;
    logic            byp_b_hit;
    logic [XLEN-1:0] byp_b_data;
    logic [31:0]     lsu_pending;
    logic [c_CW-1:0] fifo_count;

    // Arbiter side
    modport slave (
        input  alu_valid, alu_idx, alu_data,
        input  lsu_valid, lsu_idx, lsu_data,
        input  rda_idx, rdb_idx,
        output lsu_ready,
        output rf_wr_en, rf_wr_idx, rf_wr_data,
        output byp_a_hit, byp_a_data, byp_b_hit, byp_b_data,
        output lsu_pending, fifo_count
    );

    // Producer / consumer side
    modport master (
        output alu_valid, alu_idx, alu_data,
        output lsu_valid, lsu_idx, lsu_data,
        output rda_idx, rdb_idx,
        input  lsu_ready,
        input  rf_wr_en, rf_wr_idx, rf_wr_data,
        input  byp_a_hit, byp_a_data, byp_b_hit, byp_b_data,
        input  lsu_pending, fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Writeback arbiter. Merges unstalled ALU results with a
//                FIFO of long-latency LSU results onto the single regfile
//                write port; ALU always wins. Provides same-cycle bypass and
//                a pending-destination mask of queued LSU results.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    wb_arbiter_if.slave bus
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    logic [c_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CW-1:0] count_q, count_d;
    logic            wr_en_q, wr_en_d;
    logic [4:0]      wr_idx_q, wr_idx_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;

    logic [4:0]      idx_mem  [DEPTH];
    logic [XLEN-1:0] data_mem [DEPTH];

    logic             w_ready;
    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_slot_valid;
    logic [31:0]      w_pending;

    // Credit comes from the registered count only; a same-cycle pop gives none.
    assign w_ready = rst_n & (count_q < c_FULL);
    // Writes to x0 complete the handshake but are never queued.
    assign w_push  = bus.lsu_valid & w_ready & (bus.lsu_idx != 5'd0);
    // Any ALU valid, even to x0, consumes the write slot.
    assign w_pop   = ~bus.alu_valid & (count_q != '0);

    // Next-state for FIFO pointers, occupancy and the write-port registers.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        wr_en_d   = 1'b0;
        wr_idx_d  = wr_idx_q;
        wr_data_d = wr_data_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_AW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_AW'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CW'(1);
            2'b01:   count_d = count_q - c_CW'(1);
            default: count_d = count_q;
        endcase

        if (bus.alu_valid) begin
            if (bus.alu_idx != 5'd0) begin
                wr_en_d   = 1'b1;
                wr_idx_d  = bus.alu_idx;
                wr_data_d = bus.alu_data;
            end
        end else if (w_pop) begin
            wr_en_d   = 1'b1;
            wr_idx_d  = idx_mem[rd_ptr_q];
            wr_data_d = data_mem[rd_ptr_q];
        end
    end

    // Control state and write-port registers; reset discards queued entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
        end
    end

    // FIFO storage; occupancy tracking alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            idx_mem[wr_ptr_q]  <= bus.lsu_idx;
            data_mem[wr_ptr_q] <= bus.lsu_data;
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot_valid
        logic [c_AW-1:0] w_off;
        assign w_off           = c_AW'(i) - rd_ptr_q;
        assign w_slot_valid[i] = ({1'b0, w_off} < count_q);
    end

    // Pending-destination mask: OR of one-hot destinations of live slots.
    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_slot_valid[i]) begin
                w_pending[idx_mem[i]] = 1'b1;
            end
        end
        w_pending[0] = 1'b0;
    end

    assign bus.lsu_ready   = w_ready;
    assign bus.rf_wr_en    = wr_en_q;
    assign bus.rf_wr_idx   = wr_idx_q;
    assign bus.rf_wr_data  = wr_data_q;
    assign bus.byp_a_hit   = wr_en_q & (wr_idx_q == bus.rda_idx) & (bus.rda_idx != 5'd0);
    assign bus.byp_a_data  = wr_data_q;
    assign bus.byp_b_hit   = wr_en_q & (wr_idx_q == bus.rdb_idx) & (bus.rdb_idx != 5'd0);
    assign bus.byp_b_data  = wr_data_q;
    assign bus.lsu_pending = w_pending;
    assign bus.fifo_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter
//  Description : Self-checking bench for wb_arbiter: directed vector table,
//                randomized traffic against a queue-based reference model,
//                and reset corner cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } entry_t;

    typedef struct {
        logic        av;
        logic [4:0]  ai;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  li;
        logic [31:0] ld;
        logic [4:0]  ra;
        logic        en;
        logic [4:0]  wi;
        logic [31:0] wd;
        logic [2:0]  cnt;
        logic        rdy;
        logic        hit;
        logic [31:0] pend;
    } vec_t;

    logic clk;
    logic rst_n;

    wb_arbiter_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

    wb_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: queue of outstanding LSU results and expected port regs.
    entry_t      mq[$];
    logic        m_en;
    logic [4:0]  m_idx;
    logic [31:0] m_data;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p;
        p = '0;
        foreach (mq[i]) p = p | (32'd1 << mq[i].idx);
        return p;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_en   = 1'b0;
        m_idx  = '0;
        m_data = '0;
    endtask

    // Advance one clock: the model consumes the inputs presented before the
    // edge, then outputs are sampled 1 time unit after it.
    task automatic tick();
        bit accept;
        bit pop;
        accept = bus.lsu_valid && (mq.size() < DEPTH) && (bus.lsu_idx != 5'd0);
        pop    = !bus.alu_valid && (mq.size() > 0);
        if (bus.alu_valid) begin
            if (bus.alu_idx != 5'd0) begin
                m_en   = 1'b1;
                m_idx  = bus.alu_idx;
                m_data = bus.alu_data;
            end else begin
                m_en = 1'b0;
            end
        end else if (pop) begin
            m_en   = 1'b1;
            m_idx  = mq[0].idx;
            m_data = mq[0].data;
            void'(mq.pop_front());
        end else begin
            m_en = 1'b0;
        end
        if (accept) mq.push_back('{bus.lsu_idx, bus.lsu_data});
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        logic hit_a;
        logic hit_b;
        hit_a = m_en && (m_idx == bus.rda_idx) && (bus.rda_idx != 5'd0);
        hit_b = m_en && (m_idx == bus.rdb_idx) && (bus.rdb_idx != 5'd0);
        chk("rnd_wr_en",   64'(bus.rf_wr_en),    64'(m_en));
        chk("rnd_wr_idx",  64'(bus.rf_wr_idx),   64'(m_idx));
        chk("rnd_wr_data", 64'(bus.rf_wr_data),  64'(m_data));
        chk("rnd_count",   64'(bus.fifo_count),  64'(mq.size()));
        chk("rnd_ready",   64'(bus.lsu_ready),   64'(mq.size() < DEPTH));
        chk("rnd_pending", 64'(bus.lsu_pending), 64'(model_pending()));
        chk("rnd_hit_a",   64'(bus.byp_a_hit),   64'(hit_a));
        chk("rnd_hit_b",   64'(bus.byp_b_hit),   64'(hit_b));
        chk("rnd_byp_a",   64'(bus.byp_a_data),  64'(m_data));
        chk("rnd_byp_b",   64'(bus.byp_b_data),  64'(m_data));
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0;
        bus.alu_idx   = '0;
        bus.alu_data  = '0;
        bus.lsu_valid = 1'b0;
        bus.lsu_idx   = '0;
        bus.lsu_data  = '0;
        bus.rda_idx   = '0;
        bus.rdb_idx   = '0;
    endtask

    initial begin
        // av ai      ad            lv    li      ld           ra      en    wi      wd            cnt   rdy   hit   pend
        tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  5'd5,  1'b1, 5'd5,  32'hDEADBEEF, 3'd0, 1'b1, 1'b1, 32'h0};
        tbl[1]  = '{1'b1, 5'd0,  32'h123,      1'b0, 5'd0, 32'h0,  5'd0,  1'b0, 5'd5,  32'hDEADBEEF, 3'd0, 1'b1, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd7, 32'h11, 5'd7,  1'b1, 5'd3,  32'h33,       3'd1, 1'b1, 1'b0, 32'h80};
        tbl[3]  = '{1'b1, 5'd4,  32'h44,       1'b0, 5'd0, 32'h0,  5'd4,  1'b1, 5'd4,  32'h44,       3'd1, 1'b1, 1'b1, 32'h80};
        tbl[4]  = '{1'b1, 5'd6,  32'h66,       1'b0, 5'd0, 32'h0,  5'd7,  1'b1, 5'd6,  32'h66,       3'd1, 1'b1, 1'b0, 32'h80};
        tbl[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  5'd7,  1'b1, 5'd7,  32'h11,       3'd0, 1'b1, 1'b1, 32'h0};
        tbl[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  5'd7,  1'b0, 5'd7,  32'h11,       3'd0, 1'b1, 1'b0, 32'h0};
        tbl[7]  = '{1'b1, 5'd20, 32'h200,      1'b1, 5'd1, 32'hA1, 5'd20, 1'b1, 5'd20, 32'h200,      3'd1, 1'b1, 1'b1, 32'h2};
        tbl[8]  = '{1'b1, 5'd21, 32'h201,      1'b1, 5'd2, 32'hA2, 5'd0,  1'b1, 5'd21, 32'h201,      3'd2, 1'b1, 1'b0, 32'h6};
        tbl[9]  = '{1'b1, 5'd22, 32'h202,      1'b1, 5'd3, 32'hA3, 5'd22, 1'b1, 5'd22, 32'h202,      3'd3, 1'b1, 1'b1, 32'hE};
        tbl[10] = '{1'b1, 5'd23, 32'h203,      1'b1, 5'd4, 32'hA4, 5'd1,  1'b1, 5'd23, 32'h203,      3'd4, 1'b0, 1'b0, 32'h1E};
        tbl[11] = '{1'b1, 5'd24, 32'h204,      1'b1, 5'd5, 32'hA5, 5'd1,  1'b1, 5'd24, 32'h204,      3'd4, 1'b0, 1'b0, 32'h1E};
        tbl[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  5'd1,  1'b1, 5'd1,  32'hA1,       3'd3, 1'b1, 1'b1, 32'h1C};
        tbl[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  5'd2,  1'b1, 5'd2,  32'hA2,       3'd2, 1'b1, 1'b1, 32'h18};
        tbl[14] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 32'h99, 5'd3,  1'b1, 5'd3,  32'hA3,       3'd2, 1'b1, 1'b1, 32'h210};
        tbl[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  5'd9,  1'b1, 5'd4,  32'hA4,       3'd1, 1'b1, 1'b0, 32'h200};
        tbl[16] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  5'd9,  1'b1, 5'd9,  32'h99,       3'd0, 1'b1, 1'b1, 32'h0};
        tbl[17] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  5'd9,  1'b0, 5'd9,  32'h99,       3'd0, 1'b1, 1'b0, 32'h0};
        tbl[18] = '{1'b1, 5'd8,  32'h88,       1'b1, 5'd0, 32'h5,  5'd8,  1'b1, 5'd8,  32'h88,       3'd0, 1'b1, 1'b1, 32'h0};

        // ---------------- Reset held with an LSU offer present ----------------
        idle_inputs();
        rst_n         = 1'b0;
        bus.lsu_valid = 1'b1;
        bus.lsu_idx   = 5'd3;
        bus.lsu_data  = 32'h55;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",   64'(bus.lsu_ready),   64'd0);
        chk("rst_wr_en",   64'(bus.rf_wr_en),    64'd0);
        chk("rst_count",   64'(bus.fifo_count),  64'd0);
        chk("rst_pending", 64'(bus.lsu_pending), 64'd0);
        chk("rst_wr_idx",  64'(bus.rf_wr_idx),   64'd0);
        chk("rst_wr_data", 64'(bus.rf_wr_data),  64'd0);
        bus.lsu_valid = 1'b0;
        rst_n         = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_ready",   64'(bus.lsu_ready),   64'd1);
        chk("rel_wr_en",   64'(bus.rf_wr_en),    64'd0);

        // ---------------- Directed vector table ----------------
        for (int i = 0; i < 19; i++) begin
            bus.alu_valid = tbl[i].av;
            bus.alu_idx   = tbl[i].ai;
            bus.alu_data  = tbl[i].ad;
            bus.lsu_valid = tbl[i].lv;
            bus.lsu_idx   = tbl[i].li;
            bus.lsu_data  = tbl[i].ld;
            bus.rda_idx   = tbl[i].ra;
            bus.rdb_idx   = 5'd0;
            tick();
            chk($sformatf("v%0d_wr_en", i),   64'(bus.rf_wr_en),    64'(tbl[i].en));
            chk($sformatf("v%0d_wr_idx", i),  64'(bus.rf_wr_idx),   64'(tbl[i].wi));
            chk($sformatf("v%0d_wr_data", i), 64'(bus.rf_wr_data),  64'(tbl[i].wd));
            chk($sformatf("v%0d_count", i),   64'(bus.fifo_count),  64'(tbl[i].cnt));
            chk($sformatf("v%0d_ready", i),   64'(bus.lsu_ready),   64'(tbl[i].rdy));
            chk($sformatf("v%0d_hit_a", i),   64'(bus.byp_a_hit),   64'(tbl[i].hit));
            chk($sformatf("v%0d_byp_a", i),   64'(bus.byp_a_data),  64'(tbl[i].wd));
            chk($sformatf("v%0d_hit_b", i),   64'(bus.byp_b_hit),   64'd0);
            chk($sformatf("v%0d_pending", i), 64'(bus.lsu_pending), 64'(tbl[i].pend));
        end

        // ---------------- Randomized traffic vs reference model ----------------
        for (int c = 0; c < 400; c++) begin
            bus.alu_valid = ($urandom_range(0, 99) < 45);
            bus.alu_idx   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.alu_data  = $urandom;
            bus.lsu_valid = ($urandom_range(0, 99) < 55);
            bus.lsu_idx   = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.lsu_data  = $urandom;
            bus.rda_idx   = ($urandom_range(0, 1) == 1) ? bus.alu_idx : 5'($urandom_range(0, 31));
            bus.rdb_idx   = (mq.size() > 0 && $urandom_range(0, 1) == 1) ? mq[0].idx
                                                                         : 5'($urandom_range(0, 31));
            tick();
            check_model();
        end

        // ---------------- Asynchronous reset with three entries queued ----------------
        idle_inputs();
        tick();
        while (mq.size() > 0) tick();
        bus.alu_valid = 1'b1;
        bus.alu_idx   = 5'd10;
        bus.alu_data  = 32'hAAAA;
        bus.lsu_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.lsu_idx  = 5'(11 + k);
            bus.lsu_data = 32'hC0 + 32'(k);
            tick();
        end
        chk("mid_count_pre", 64'(bus.fifo_count), 64'd3);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_wr_en",   64'(bus.rf_wr_en),    64'd0);
        chk("mid_wr_idx",  64'(bus.rf_wr_idx),   64'd0);
        chk("mid_wr_data", 64'(bus.rf_wr_data),  64'd0);
        chk("mid_count",   64'(bus.fifo_count),  64'd0);
        chk("mid_pending", 64'(bus.lsu_pending), 64'd0);
        chk("mid_ready",   64'(bus.lsu_ready),   64'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("post_wr_en", 64'(bus.rf_wr_en),   64'd0);
            chk("post_count", 64'(bus.fifo_count), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
